// File: rtl/bcd_counter_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_counter_n_if : control/data bundle for bcd_counter_n (rev 1.0)       |
// +--------------------------------------------------------------------------+
interface bcd_counter_n_if #(
  parameter int DIGITS = 4
);
  logic                  ce;
  logic                  l;
  logic                  up;
  logic                  sclr;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  ceo;
  logic                  ovf;

  modport master (output ce, l, up, sclr, d, input q, tc, ceo, ovf);
  modport slave  (input ce, l, up, sclr, d, output q, tc, ceo, ovf);
endinterface
`default_nettype wire

// File: rtl/bcd_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_counter_n : N-digit loadable, cascadable up/down BCD counter (rev 1.0)|
// +--------------------------------------------------------------------------+
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter int SAT    = 0
) (
  input  wire logic      clk,
  input  wire logic      clr_n,
  bcd_counter_n_if.slave bus
);
  localparam logic [3:0] c_nine = 4'd9;

  logic [4*DIGITS-1:0] r_q;
  logic                r_ovf;
  logic [4*DIGITS-1:0] w_q_cnt;
  logic [4*DIGITS-1:0] w_d_clamp;
  logic [3:0]          w_cur;
  logic [3:0]          w_ld;
  logic                w_all9;
  logic                w_all0;
  logic                w_tc;

  // Ripple carry/borrow: w_all9/w_all0 hold "all lower digits are 9/0" on entry to digit k.
  always_comb begin
    w_all9    = 1'b1;
    w_all0    = 1'b1;
    w_q_cnt   = '0;
    w_d_clamp = '0;
    w_cur     = 4'd0;
    w_ld      = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      w_cur = r_q[4*k +: 4];
      w_ld  = bus.d[4*k +: 4];
      if (bus.up)
        w_q_cnt[4*k +: 4] = !w_all9 ? w_cur : ((w_cur == c_nine) ? 4'd0 : w_cur + 4'd1);
      else
        w_q_cnt[4*k +: 4] = !w_all0 ? w_cur : ((w_cur == 4'd0) ? c_nine : w_cur - 4'd1);
      w_d_clamp[4*k +: 4] = (w_ld > c_nine) ? c_nine : w_ld;
      w_all9 = w_all9 & (w_cur == c_nine);
      w_all0 = w_all0 & (w_cur == 4'd0);
    end
    w_tc = bus.up ? w_all9 : w_all0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (bus.sclr) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else if (bus.l) begin
      r_q   <= w_d_clamp;
      r_ovf <= 1'b0;
    end else if (bus.ce) begin
      r_ovf <= r_ovf | w_tc;
      // Saturating build freezes q at the limit; wrapping build lets the chain roll over.
      if (!((SAT != 0) && w_tc))
        r_q <= w_q_cnt;
    end
  end

  assign bus.q   = r_q;
  assign bus.ovf = r_ovf;
  assign bus.tc  = w_tc;
  assign bus.ceo = bus.ce & w_tc;
endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_counter_n : directed bench for wrap, saturate and cascaded builds  |
// +--------------------------------------------------------------------------+
module tb_bcd_counter_n;
  logic clk;
  logic clr_n;
  int   errors;
  int   checks;

  bcd_counter_n_if #(.DIGITS(4)) bus_a  ();
  bcd_counter_n_if #(.DIGITS(4)) bus_s  ();
  bcd_counter_n_if #(.DIGITS(2)) bus_lo ();
  bcd_counter_n_if #(.DIGITS(2)) bus_hi ();

  bcd_counter_n #(.DIGITS(4), .SAT(0)) u_dut_a  (.clk(clk), .clr_n(clr_n), .bus(bus_a));
  bcd_counter_n #(.DIGITS(4), .SAT(1)) u_dut_s  (.clk(clk), .clr_n(clr_n), .bus(bus_s));
  bcd_counter_n #(.DIGITS(2), .SAT(0)) u_dut_lo (.clk(clk), .clr_n(clr_n), .bus(bus_lo));
  bcd_counter_n #(.DIGITS(2), .SAT(0)) u_dut_hi (.clk(clk), .clr_n(clr_n), .bus(bus_hi));

  // Cascade: high pair counts on the low pair's ceo and shares its direction.
  assign bus_hi.ce = bus_lo.ceo;
  assign bus_hi.up = bus_lo.up;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr_n  = 1'b0;
    {bus_a.ce, bus_a.l, bus_a.up, bus_a.sclr} = 4'b0;
    {bus_s.ce, bus_s.l, bus_s.up, bus_s.sclr} = 4'b0;
    {bus_lo.ce, bus_lo.l, bus_lo.up, bus_lo.sclr} = 4'b0;
    {bus_hi.l, bus_hi.sclr} = 2'b0;
    bus_a.d = '0; bus_s.d = '0; bus_lo.d = '0; bus_hi.d = '0;

    // Reset state
    tick(); tick();
    chk("rst_q",   32'(bus_a.q), 32'h0000);
    chk("rst_ovf", 32'(bus_a.ovf), 32'd0);
    chk("rst_tc_dn", 32'(bus_a.tc), 32'd1);
    chk("rst_ceo_ce0", 32'(bus_a.ceo), 32'd0);
    bus_a.ce = 1'b1; #1;
    chk("rst_ceo_ce1", 32'(bus_a.ceo), 32'd1);
    bus_a.up = 1'b1; #1;
    chk("rst_tc_up", 32'(bus_a.tc), 32'd0);

    // Up-count 12 cycles with carry at 0009->0010
    tick();
    clr_n = 1'b1;
    repeat (9) tick();
    chk("cnt9", 32'(bus_a.q), 32'h0009);
    tick();
    chk("cnt10", 32'(bus_a.q), 32'h0010);
    tick(); tick();
    chk("cnt12", 32'(bus_a.q), 32'h0012);

    // Multi-digit carry and borrow
    bus_a.ce = 1'b0; bus_a.l = 1'b1; bus_a.d = 16'h0999; tick();
    bus_a.l = 1'b0; bus_a.ce = 1'b1; bus_a.up = 1'b1; tick();
    chk("carry", 32'(bus_a.q), 32'h1000);
    bus_a.ce = 1'b0; bus_a.l = 1'b1; bus_a.d = 16'h1000; tick();
    bus_a.l = 1'b0; bus_a.ce = 1'b1; bus_a.up = 1'b0; tick();
    chk("borrow", 32'(bus_a.q), 32'h0999);

    // Wrap and sticky overflow
    bus_a.ce = 1'b0; bus_a.l = 1'b1; bus_a.d = 16'h9998; tick();
    bus_a.l = 1'b0; bus_a.ce = 1'b1; bus_a.up = 1'b1; tick();
    chk("wrap_9999", 32'(bus_a.q), 32'h9999);
    chk("wrap_tc", 32'(bus_a.tc), 32'd1);
    chk("wrap_ceo", 32'(bus_a.ceo), 32'd1);
    chk("wrap_ovf0", 32'(bus_a.ovf), 32'd0);
    tick();
    chk("wrap_0000", 32'(bus_a.q), 32'h0000);
    chk("wrap_ovf1", 32'(bus_a.ovf), 32'd1);
    tick();
    chk("wrap_0001", 32'(bus_a.q), 32'h0001);
    chk("wrap_ovf_sticky", 32'(bus_a.ovf), 32'd1);
    bus_a.ce = 1'b0; bus_a.l = 1'b1; bus_a.d = 16'h0005; tick();
    chk("load_q", 32'(bus_a.q), 32'h0005);
    chk("load_clr_ovf", 32'(bus_a.ovf), 32'd0);

    // Down wrap, then sclr clears ovf
    bus_a.d = 16'h0000; tick();
    bus_a.l = 1'b0; bus_a.ce = 1'b1; bus_a.up = 1'b0; tick();
    chk("dnwrap_q", 32'(bus_a.q), 32'h9999);
    chk("dnwrap_ovf", 32'(bus_a.ovf), 32'd1);
    bus_a.ce = 1'b0; bus_a.sclr = 1'b1; tick();
    bus_a.sclr = 1'b0;
    chk("sclr_q", 32'(bus_a.q), 32'h0000);
    chk("sclr_ovf", 32'(bus_a.ovf), 32'd0);

    // Load clamp and priority
    bus_a.l = 1'b1; bus_a.d = 16'h3A5F; tick();
    chk("clamp", 32'(bus_a.q), 32'h3959);
    bus_a.sclr = 1'b1; bus_a.d = 16'h1234; tick();
    bus_a.sclr = 1'b0;
    chk("sclr_over_l", 32'(bus_a.q), 32'h0000);
    bus_a.ce = 1'b1; bus_a.up = 1'b1; bus_a.d = 16'h0042; tick();
    chk("l_over_ce", 32'(bus_a.q), 32'h0042);
    bus_a.l = 1'b0; bus_a.ce = 1'b0; tick();
    chk("hold", 32'(bus_a.q), 32'h0042);

    // Saturating build
    bus_s.l = 1'b1; bus_s.d = 16'h0001; tick();
    bus_s.l = 1'b0; bus_s.ce = 1'b1; bus_s.up = 1'b0; tick();
    chk("sat_c1_q", 32'(bus_s.q), 32'h0000);
    chk("sat_c1_ovf", 32'(bus_s.ovf), 32'd0);
    tick();
    chk("sat_c2_q", 32'(bus_s.q), 32'h0000);
    chk("sat_c2_tc", 32'(bus_s.tc), 32'd1);
    chk("sat_c2_ovf", 32'(bus_s.ovf), 32'd1);
    tick();
    chk("sat_c3_q", 32'(bus_s.q), 32'h0000);
    chk("sat_c3_ovf", 32'(bus_s.ovf), 32'd1);
    bus_s.ce = 1'b0; bus_s.up = 1'b1; #1;
    chk("sat_tc_comb", 32'(bus_s.tc), 32'd0);
    bus_s.l = 1'b1; bus_s.d = 16'h9999; tick();
    bus_s.l = 1'b0; bus_s.ce = 1'b1; tick();
    chk("sat_up_q", 32'(bus_s.q), 32'h9999);
    chk("sat_up_ovf", 32'(bus_s.ovf), 32'd1);
    bus_s.ce = 1'b0;

    // Cascaded pair
    bus_lo.l = 1'b1; bus_lo.d = 8'h99; bus_hi.l = 1'b1; bus_hi.d = 8'h00; tick();
    bus_lo.l = 1'b0; bus_hi.l = 1'b0; bus_lo.ce = 1'b1; bus_lo.up = 1'b1; #1;
    chk("casc_ceo", 32'(bus_lo.ceo), 32'd1);
    tick();
    chk("casc_0100", 32'({bus_hi.q, bus_lo.q}), 32'h0100);
    tick(); tick();
    chk("casc_0102", 32'({bus_hi.q, bus_lo.q}), 32'h0102);

    // Asynchronous clear mid-cycle
    @(negedge clk); #1;
    clr_n = 1'b0; #1;
    chk("async_casc", 32'({bus_hi.q, bus_lo.q}), 32'h0000);
    chk("async_a", 32'(bus_a.q), 32'h0000);
    chk("async_s_ovf", 32'(bus_s.ovf), 32'd0);
    #1 clr_n = 1'b1;
    tick();
    chk("resume", 32'({bus_hi.q, bus_lo.q}), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
